tt_um_rr_priority_arbiter: RTL and testbench



---
 rtl/tt_um_rr_priority_arbiter.sv | 125 ++++++++++++
 tb/tb_tt_um_rr_priority_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_rr_priority_arbiter.sv
// Round-robin arbiter sharing one downstream resource among 16 requesters.
// Requests arrive packed as {ui_in, uio_in}, bit 15 highest. Grants are held
// while the winner keeps requesting, bounded by MAX_HOLD cycles, and priority
// rotates past each winner on release.
module tt_um_rr_priority_arbiter #(
    parameter int unsigned MAX_HOLD = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned REQ_W = 16;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [REQ_W-1:0]   req_q;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic               timeout_q, timeout_d;
    logic               any_req_q;
    logic [IDX_W:0]     pick;

    // ena carries no information for this block
    logic unused_ena;
    assign unused_ena = ena;

    // Search start, start-1, ... (mod 16); returns {found, index} of the first set bit
    function automatic logic [IDX_W:0] rr_pick(input logic [REQ_W-1:0] req,
                                               input logic [IDX_W-1:0] start);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] idx;
        res = '0;
        for (int i = REQ_W - 1; i >= 0; i--) begin
            idx = start - IDX_W'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt_idx_d   = gnt_idx_q;
        timeout_d   = 1'b0;
        pick        = rr_pick(req_q, ptr_q);

        unique case (state_q)
            IDLE: begin
                if (pick[IDX_W]) begin
                    state_d   = GRANT;
                    gnt_idx_d = pick[IDX_W-1:0];
                    cnt_d     = '0;
                end
            end
            GRANT: begin
                // a dropped request wins over an expiring hold: no timeout flag then
                if (!req_q[gnt_idx_q]) begin
                    state_d = RELEASE;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d   = RELEASE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                state_d = IDLE;
                ptr_d   = gnt_idx_q - IDX_W'(1);
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        gnt_valid_d = (state_d == GRANT);
    end

    // State, input sample and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            ptr_q       <= IDX_W'(REQ_W - 1);
            cnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            any_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= {ui_in, uio_in};
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            any_req_q   <= |req_q;
        end
    end

    assign uo_out  = {1'b0, any_req_q, timeout_q, gnt_valid_q, gnt_idx_q};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_rr_priority_arbiter.sv
// Directed bench for the round-robin arbiter. Stimulus pushes the expected
// grant records; a negedge monitor rebuilds each finished grant and checks it.
module tb_tt_um_rr_priority_arbiter;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int vectors;
    int miscompares;

    // one completed grant: index, cycles held, timeout flag at release, gap before it (0 = don't care)
    typedef struct {
        logic [3:0] idx;
        int         len;
        logic       to;
        int         gap;
    } rec_t;

    rec_t exp_q[$];

    tt_um_rr_priority_arbiter #(.MAX_HOLD(64)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_req(input logic [15:0] r);
        {ui_in, uio_in} = r;
    endtask

    task automatic push(input logic [3:0] idx, input int len, input logic to, input int gap);
        rec_t r;
        r.idx = idx; r.len = len; r.to = to; r.gap = gap;
        exp_q.push_back(r);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic apply_reset(input logic [15:0] r);
        @(negedge clk);
        rst_n = 1'b0;
        set_req(r);
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input string name);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (uo_out[4]) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL %s: no grant within 500 cycles", name);
    endtask

    task automatic wait_timeout(input string name);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (uo_out[5]) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL %s: no timeout within 500 cycles", name);
    endtask

    // Monitor: rebuild each grant from gnt_valid edges and compare with the queue
    logic       prev_v;
    logic       have_prev;
    int         hi_cnt;
    int         lo_cnt;
    int         gap_start;
    logic [3:0] cur_idx;

    always @(negedge clk) begin
        rec_t e;
        logic v;
        if (!rst_n) begin
            prev_v    = 1'b0;
            have_prev = 1'b0;
            hi_cnt    = 0;
            lo_cnt    = 0;
        end else begin
            v = uo_out[4];
            if (uo_out[5]) begin
                vectors++;
                if (!(prev_v && !v)) begin
                    miscompares++;
                    $display("FAIL stray_timeout: timeout=1 with gnt_valid=%0b prev=%0b", v, prev_v);
                end
            end
            if (v && !prev_v) begin
                gap_start = have_prev ? lo_cnt : 0;
                hi_cnt    = 0;
                cur_idx   = uo_out[3:0];
            end
            if (v) hi_cnt++;
            if (!v && prev_v) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL grant_unexpected: idx=%0d len=%0d to=%0b, none expected",
                             cur_idx, hi_cnt, uo_out[5]);
                end else begin
                    e = exp_q.pop_front();
                    if (cur_idx !== e.idx || hi_cnt != e.len || uo_out[5] !== e.to ||
                        (e.gap != 0 && gap_start != e.gap)) begin
                        miscompares++;
                        $display("FAIL grant_record: got idx=%0d len=%0d to=%0b gap=%0d expected idx=%0d len=%0d to=%0b gap=%0d",
                                 cur_idx, hi_cnt, uo_out[5], gap_start, e.idx, e.len, e.to, e.gap);
                    end
                end
                have_prev = 1'b1;
                lo_cnt    = 0;
            end
            if (!v) lo_cnt++;
            prev_v = v;
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        ena         = 1'b1;
        rst_n       = 1'b0;
        set_req(16'h0000);

        // Reset and single request on idx 2
        tick(2);
        set_req(16'h0004);
        tick(1);
        check("reset_uo_out", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'h00);
        push(4'd2, 6, 1'b0, 0);
        rst_n = 1'b1;
        tick(1);
        check("latency_edge1", uo_out, 8'h00);
        tick(1);
        check("latency_edge2", uo_out, 8'h52);
        tick(4);
        set_req(16'h0000);
        tick(3);
        check("ptr_after_idx2", 8'(dut.ptr_q), 8'h01);

        // Fixed priority after reset, then rotation to idx 0
        apply_reset(16'h8001);
        push(4'd15, 64, 1'b1, 0);
        push(4'd0, 64, 1'b1, 2);
        wait_timeout("prio_timeout1");
        wait_timeout("prio_timeout2");
        set_req(16'h0000);
        tick(4);

        // Round-robin fairness: all request, each drops 3 cycles into its grant
        apply_reset(16'hFFFF);
        for (int k = 0; k < 17; k++) begin
            push(4'(15 - k), 3, 1'b0, (k == 0) ? 0 : 2);
        end
        for (int k = 0; k < 17; k++) begin
            logic [15:0] r;
            logic [3:0]  g;
            wait_grant("rr_grant");
            g = uo_out[3:0];
            tick(1);
            r = {ui_in, uio_in};
            r[g] = 1'b0;
            set_req((k == 16) ? 16'h0000 : r);
            tick(2);
            if (k != 16) begin
                r[g] = 1'b1;
                set_req(r);
            end
        end
        tick(4);

        // Timeout on idx 4, regrant after the gap
        apply_reset(16'h0010);
        push(4'd4, 64, 1'b1, 0);
        push(4'd4, 2, 1'b0, 2);
        wait_timeout("to_timeout");
        wait_grant("to_regrant");
        set_req(16'h0000);
        tick(4);

        // Pointer wrap: grant idx 0 from ptr=3, release leaves ptr=15
        set_req(16'h0001);
        push(4'd0, 2, 1'b0, 0);
        wait_grant("wrap_grant");
        set_req(16'h0000);
        tick(3);
        check("ptr_wrap", 8'(dut.ptr_q), 8'h0F);

        // Drop on the same cycle the hold would expire: no timeout
        tick(2);
        set_req(16'h0001);
        push(4'd0, 64, 1'b0, 0);
        wait_grant("drop_vs_to_grant");
        tick(62);
        set_req(16'h0000);
        tick(4);

        // Async reset in the middle of a grant on idx 9
        apply_reset(16'h0200);
        wait_grant("arst_grant");
        tick(3);
        check("arst_before", uo_out, 8'h59);
        #2;
        rst_n = 1'b0;
        set_req(16'h0300);
        #1;
        check("arst_immediate", uo_out, 8'h00);
        tick(2);
        rst_n = 1'b1;
        push(4'd9, 2, 1'b0, 0);
        wait_grant("arst_regrant");
        set_req(16'h0000);
        tick(5);

        check("queue_drained", 8'(exp_q.size()), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
